// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// ---------------
// Generates VGA raster timing (640x480@60 Hz by default) from the system
// clock. A free-running divider produces a one-clk pixel strobe; on every
// strobe the (x,y) position advances and all raster outputs are re-decoded
// from the new position, so every output describes the current (x,y) with
// no relative skew.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset (deassert is pre-synchronised)
//   pclk_en      one-clk strobe every CLK_DIV clks; position advances after it
//   h_sync       horizontal sync, active low
//   v_sync       vertical sync, active low
//   DE           high while (x,y) is inside the visible area
//   x_pixel      horizontal position, 0..H_TOTAL-1
//   y_pixel      vertical position, 0..V_TOTAL-1
//   line_start   high for the pixel period at x==0 (after the first wrap)
//   frame_start  high for the pixel period at (0,0) (after the first wrap)
//
// Handshake: there is no valid/ready pair. Every output is valid on every
// clk; consumers qualify with pclk_en or simply sample the held values.
// H_TOTAL and V_TOTAL must both fit in 10 bits.
module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_RES   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_RES   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       pclk_en,
  output logic       h_sync,
  output logic       v_sync,
  output logic       DE,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  // A 1-bit divider is kept even for CLK_DIV==1; it then simply stays at 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS = 10'(H_RES);
  localparam logic [9:0] V_VIS = 10'(V_RES);
  localparam logic [9:0] H_SS  = 10'(H_RES + H_FP);
  localparam logic [9:0] H_SE  = 10'(H_RES + H_FP + H_SYNC);
  localparam logic [9:0] V_SS  = 10'(V_RES + V_FP);
  localparam logic [9:0] V_SE  = 10'(V_RES + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [9:0]       x_nxt;
  logic [9:0]       y_nxt;

  always_comb begin
    div_nxt = div_cnt + DIV_W'(1);
    if (div_cnt == DIV_MAX) begin
      div_nxt = '0;
    end
  end

  // Next raster position; y only moves when x wraps.
  always_comb begin
    x_nxt = x_pixel + 10'd1;
    y_nxt = y_pixel;
    if (x_pixel == H_MAX) begin
      x_nxt = '0;
      if (y_pixel == V_MAX) begin
        y_nxt = '0;
      end else begin
        y_nxt = y_pixel + 10'd1;
      end
    end
  end

  // Outputs are decoded from the *next* position so they land on the same
  // edge as x_pixel/y_pixel. v_sync is decoded from y only, which changes
  // only on the x wrap, so it toggles exactly at x==0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      pclk_en     <= 1'b0;
      x_pixel     <= '0;
      y_pixel     <= '0;
      DE          <= 1'b1;
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      pclk_en <= (div_nxt == DIV_MAX);
      if (pclk_en) begin
        x_pixel     <= x_nxt;
        y_pixel     <= y_nxt;
        DE          <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
        h_sync      <= !((x_nxt >= H_SS) && (x_nxt < H_SE));
        v_sync      <= !((y_nxt >= V_SS) && (y_nxt < V_SE));
        line_start  <= (x_nxt == 10'd0);
        frame_start <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Three instances share one clock and reset:
//   dut_a: default geometry, CLK_DIV=4
//   dut_b: small geometry (H 8/2/3/2 = 15, V 6/2/2/1 = 11), CLK_DIV=4
//   dut_c: default geometry, CLK_DIV=1
// A reference model pushes the expected output vector of every instance into
// a queue on each rising edge; a monitor pops and compares on the falling
// edge. Directed measurements check hand-computed line/frame figures.
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       pe_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       pe_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;
  logic       pe_c, hs_c, vs_c, de_c, ls_c, fs_c;
  logic [9:0] x_c, y_c;

  logic [25:0] vec_a, vec_b, vec_c;
  assign vec_a = {pe_a, hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a};
  assign vec_b = {pe_b, hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b};
  assign vec_c = {pe_c, hs_c, vs_c, de_c, x_c, y_c, ls_c, fs_c};

  // {pclk_en,h_sync,v_sync,DE,x,y,line_start,frame_start} while in reset
  localparam logic [25:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 1'b0};

  vga_timing_gen dut_a (
    .clk(clk), .reset_n(reset_n), .pclk_en(pe_a), .h_sync(hs_a), .v_sync(vs_a),
    .DE(de_a), .x_pixel(x_a), .y_pixel(y_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CLK_DIV(4), .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_RES(6), .V_FP(2), .V_SYNC(2), .V_BP(1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .pclk_en(pe_b), .h_sync(hs_b), .v_sync(vs_b),
    .DE(de_b), .x_pixel(x_b), .y_pixel(y_b), .line_start(ls_b), .frame_start(fs_b)
  );

  vga_timing_gen #(.CLK_DIV(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .pclk_en(pe_c), .h_sync(hs_c), .v_sync(vs_c),
    .DE(de_c), .x_pixel(x_c), .y_pixel(y_c), .line_start(ls_c), .frame_start(fs_c)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_vec(input string name, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got pe=%b hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b, expected pe=%b hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
               name, $time, act[25], act[24], act[23], act[22], act[21:12], act[11:2], act[1], act[0],
               exp[25], exp[24], exp[23], exp[22], exp[21:12], exp[11:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // n = rising edges since reset release, p = completed pixel periods.
  function automatic logic [25:0] model(input int n, input int p, input int d,
                                        input int hr, input int hf, input int hs, input int hb,
                                        input int vr, input int vf, input int vs, input int vb);
    int ht, vt, x, y;
    logic pe, de, hsy, vsy, ls, fs;
    ht  = hr + hf + hs + hb;
    vt  = vr + vf + vs + vb;
    x   = p % ht;
    y   = (p / ht) % vt;
    pe  = (n >= 1) && ((n % d) == d - 1);
    de  = (x < hr) && (y < vr);
    hsy = !((x >= hr + hf) && (x < hr + hf + hs));
    vsy = !((y >= vr + vf) && (y < vr + vf + vs));
    ls  = (x == 0) && (p >= ht);
    fs  = (x == 0) && (y == 0) && (p >= ht * vt);
    return {pe, hsy, vsy, de, 10'(x), 10'(y), ls, fs};
  endfunction

  logic [25:0] exp_q_a[$];
  logic [25:0] exp_q_b[$];
  logic [25:0] exp_q_c[$];
  int m_n  = 0;
  int m_p4 = 0;
  int m_p1 = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_n  = 0;
      m_p4 = 0;
      m_p1 = 0;
    end else begin
      if (m_n >= 1 && (m_n % 4) == 3) m_p4++;
      if (m_n >= 1) m_p1++;
      m_n++;
    end
    exp_q_a.push_back(model(m_n, m_p4, 4, 640, 16, 96, 48, 480, 10, 2, 33));
    exp_q_b.push_back(model(m_n, m_p4, 4, 8, 2, 3, 2, 6, 2, 2, 1));
    exp_q_c.push_back(model(m_n, m_p1, 1, 640, 16, 96, 48, 480, 10, 2, 33));
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (exp_q_a.size() > 0) check_vec("sb_a", vec_a, exp_q_a.pop_front());
    if (exp_q_b.size() > 0) check_vec("sb_b", vec_b, exp_q_b.pop_front());
    if (exp_q_c.size() > 0) check_vec("sb_c", vec_c, exp_q_c.pop_front());
  end

  // ---------------- directed measurements ----------------
  int a_first_pe = -1, a_de = 0, a_hs = 0, a_hs_first = -1, a_hs_last = -1;
  int a_wrap_x = -1, a_wrap_y = -1, a_done = 0;
  int b_c1 = -1, b_c2 = -1, b_de = 0, b_vs = 0, b_vs_x = -1, b_vs_y = -1, b_fs_hi = 0;
  logic b_prev_fs = 1'b0;
  int c_zeros = 0, c_l1 = -1, c_l2 = -1;
  logic c_prev_ls = 1'b0;
  int r_found = 0, r_fs = 0, r_first_ls = -1;

  initial begin
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check_vec("reset_a", vec_a, RST_VEC);
    check_vec("reset_b", vec_b, RST_VEC);
    check_vec("reset_c", vec_c, RST_VEC);
    reset_n = 1'b1;

    fork
      begin : line_a
        for (int k = 1; k <= 4000 && a_done == 0; k++) begin
          @(negedge clk);
          if (pe_a && a_first_pe < 0) a_first_pe = k;
          if (pe_a) begin
            if (y_a == 10'd0) begin
              if (de_a) a_de++;
              if (!hs_a) begin
                a_hs++;
                if (a_hs_first < 0) a_hs_first = int'(x_a);
                a_hs_last = int'(x_a);
              end
            end else begin
              a_wrap_x = int'(x_a);
              a_wrap_y = int'(y_a);
              a_done = 1;
            end
          end
        end
      end
      begin : frame_b
        for (int k = 1; k <= 1500 && b_c2 < 0; k++) begin
          @(negedge clk);
          if (fs_b && !b_prev_fs) begin
            if (b_c1 < 0) b_c1 = k;
            else b_c2 = k;
          end
          b_prev_fs = fs_b;
          if (b_c1 >= 0 && b_c2 < 0) begin
            if (fs_b) b_fs_hi++;
            if (pe_b) begin
              if (de_b) b_de++;
              if (!vs_b) begin
                b_vs++;
                if (b_vs_y < 0) begin
                  b_vs_x = int'(x_b);
                  b_vs_y = int'(y_b);
                end
              end
            end
          end
        end
      end
      begin : line_c
        for (int k = 1; k <= 2000; k++) begin
          @(negedge clk);
          if (!pe_c) c_zeros++;
          if (ls_c && !c_prev_ls) begin
            if (c_l1 < 0) c_l1 = k;
            else if (c_l2 < 0) c_l2 = k;
          end
          c_prev_ls = ls_c;
        end
      end
    join

    check_int("first_pclk_en_edge", a_first_pe, 3);
    check_int("line_wrap_seen", a_done, 1);
    check_int("line_de_count", a_de, 640);
    check_int("line_hsync_count", a_hs, 96);
    check_int("line_hsync_first_x", a_hs_first, 656);
    check_int("line_hsync_last_x", a_hs_last, 751);
    check_int("line_wrap_x", a_wrap_x, 0);
    check_int("line_wrap_y", a_wrap_y, 1);
    check_int("frame_first_start_edge", b_c1, 660);
    check_int("frame_period_clks", b_c2 - b_c1, 660);
    check_int("frame_de_count", b_de, 48);
    check_int("frame_vsync_pixels", b_vs, 30);
    check_int("frame_vsync_start_x", b_vs_x, 0);
    check_int("frame_vsync_start_y", b_vs_y, 8);
    check_int("frame_start_width_clks", b_fs_hi, 4);
    check_int("div1_pclk_en_low_clks", c_zeros, 0);
    check_int("div1_first_line_edge", c_l1, 801);
    check_int("div1_line_period_clks", c_l2 - c_l1, 800);

    // Mid-frame reset on the small raster at (5,3).
    for (int k = 0; k < 700 && r_found == 0; k++) begin
      @(negedge clk);
      if (x_b == 10'd5 && y_b == 10'd3) r_found = 1;
    end
    check_int("midrst_position_found", r_found, 1);
    #1 reset_n = 1'b0;
    #1;
    check_vec("midrst_async_b", vec_b, RST_VEC);
    check_vec("midrst_async_a", vec_a, RST_VEC);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (fs_b) r_fs++;
      if (ls_b && r_first_ls < 0) r_first_ls = k;
    end
    check_int("midrst_no_frame_start", r_fs, 0);
    check_int("midrst_first_line_edge", r_first_ls, 60);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
